// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller.
//   state_e   : controller FSM states
//   bcd_t     : one 4-bit BCD digit
//   stamp_t   : full time stamp, seven BCD digits (min1 in the MSBs, ms0 in the LSBs)
//   MS_MAX, SEC_MAX : highest millisecond and second values before carry
//   bcd_digit / digit_modulus : constant helpers used to size the digit chain
package stopwatch_pkg;

   localparam int unsigned MS_MAX  = 999;
   localparam int unsigned SEC_MAX = 59;

   typedef logic [3:0] bcd_t;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StRunning = 2'd1,
      StPaused  = 2'd2
   } state_e;

   typedef struct packed {
      bcd_t min1;
      bcd_t min0;
      bcd_t sec1;
      bcd_t sec0;
      bcd_t ms2;
      bcd_t ms1;
      bcd_t ms0;
   } stamp_t;

   // Decimal digit 'pos' (0 = units) of 'value'.
   function automatic bcd_t bcd_digit(int unsigned value, int unsigned pos);
      int unsigned v;
      v = value;
      for (int unsigned i = 0; i < pos; i++) begin
         v = v / 10;
      end
      return bcd_t'(v % 10);
   endfunction

   // Roll-over modulus of digit 'idx' in the chain (0 = ms units .. 6 = minutes tens).
   // Minutes digits count freely 0-9; the MAX_MINUTES limit is applied as a wrap.
   function automatic int unsigned digit_modulus(int unsigned idx);
      if (idx < 3) begin
         return 32'(bcd_digit(MS_MAX, idx)) + 1;
      end
      if (idx < 5) begin
         return 32'(bcd_digit(SEC_MAX, idx - 3)) + 1;
      end
      return 10;
   endfunction

endpackage

// File: rtl/stopwatch_controller_if.sv
// Signal bundle between the stopwatch controller and its environment.
//   startBtn/stopBtn/resetBtn/lapBtn : one-cycle button requests
//   oneMilliSecond                   : one-cycle tick from the 1 ms timer
//   preload/preloadTime              : load a time stamp into the count (test/debug hook)
//   enableTimer, msDigits, secDigits, minDigits, running, overflow : controller outputs
// modport slave is the controller side, modport master the environment side.
interface stopwatch_controller_if;
   import stopwatch_pkg::*;

   logic        startBtn;
   logic        stopBtn;
   logic        resetBtn;
   logic        lapBtn;
   logic        oneMilliSecond;
   logic        preload;
   stamp_t      preloadTime;

   logic        enableTimer;
   logic [11:0] msDigits;
   logic [7:0]  secDigits;
   logic [7:0]  minDigits;
   logic        running;
   logic        overflow;

   modport master (
      output startBtn, stopBtn, resetBtn, lapBtn, oneMilliSecond, preload, preloadTime,
      input  enableTimer, msDigits, secDigits, minDigits, running, overflow
   );

   modport slave (
      input  startBtn, stopBtn, resetBtn, lapBtn, oneMilliSecond, preload, preloadTime,
      output enableTimer, msDigits, secDigits, minDigits, running, overflow
   );

endinterface

// File: rtl/bcd_digit_counter.sv
// One modulo-Modulus BCD digit of a ripple digit chain.
//   clk, rst_n   : clock, asynchronous active-low reset
//   clr_i        : synchronous clear (highest priority)
//   load_i       : load load_val_i (out-of-range values load as 0)
//   inc_i        : carry-in, advance by one
//   digit_o      : current digit
//   carry_o      : carry-out, inc_i while the digit sits at Modulus-1
module bcd_digit_counter
   import stopwatch_pkg::*;
#(
   parameter int unsigned Modulus = 10
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic load_i,
   input  bcd_t load_val_i,
   input  logic inc_i,
   output bcd_t digit_o,
   output logic carry_o
);

   localparam bcd_t Top = bcd_t'(Modulus - 1);

   bcd_t digit_q, digit_d;

   assign carry_o = inc_i && (digit_q == Top);
   assign digit_o = digit_q;

   always_comb begin
      digit_d = digit_q;
      if (clr_i) begin
         digit_d = '0;
      end else if (load_i) begin
         // Never let a bad load put a non-decimal code on the outputs.
         digit_d = (load_val_i > Top) ? '0 : load_val_i;
      end else if (inc_i) begin
         digit_d = (digit_q == Top) ? '0 : digit_q + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digit_q <= '0;
      end else begin
         digit_q <= digit_d;
      end
   end

endmodule

// File: rtl/stopwatch_controller.sv
// Stopwatch controller: IDLE/RUNNING/PAUSED FSM driving a seven-digit BCD
// mm:ss.mmm count advanced by 1 ms ticks, wrapping after MAX_MINUTES:59.999.
//   clk, rst_n : 50 MHz clock, asynchronous active-low reset
//   sw         : stopwatch_controller_if.slave (buttons, tick, preload, outputs)
// Optional: define STOPWATCH_LAP_EN to add lap capture (frozen display while
// the count continues); otherwise lapBtn is ignored and the live count shown.
module stopwatch_controller
   import stopwatch_pkg::*;
#(
   parameter int unsigned MAX_MINUTES = 59
) (
   input  logic                  clk,
   input  logic                  rst_n,
   stopwatch_controller_if.slave sw
);

   localparam stamp_t MaxStamp = {
      bcd_digit(MAX_MINUTES, 1), bcd_digit(MAX_MINUTES, 0),
      bcd_digit(SEC_MAX, 1), bcd_digit(SEC_MAX, 0),
      bcd_digit(MS_MAX, 2), bcd_digit(MS_MAX, 1), bcd_digit(MS_MAX, 0)
   };

   state_e          state_q, state_d;
   logic            enable_q, overflow_q;
   logic            tick, load, wrap, clr;
   logic [6:0]      inc, carry;
   logic [6:0][3:0] live_vec, load_vec;
   stamp_t          live, shown;
   logic            unused_carry;

   // ---------------- FSM ----------------
   always_comb begin
      state_d = state_q;
      if (sw.resetBtn) begin
         state_d = StIdle;
      end else begin
         case (state_q)
            StRunning: if (sw.stopBtn) state_d = StPaused;
            // Start together with stop is treated as no request.
            StIdle, StPaused: if (sw.startBtn && !sw.stopBtn) state_d = StRunning;
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         enable_q   <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         enable_q   <= (state_d == StRunning);
         overflow_q <= wrap;
      end
   end

   // ---------------- digit chain ----------------
   // A tick coinciding with stop still counts (state is RUNNING); with reset it is dropped.
   assign tick     = sw.oneMilliSecond && (state_q == StRunning) && !sw.resetBtn;
   assign load     = sw.preload && !sw.resetBtn;
   assign wrap     = tick && !load && (live == MaxStamp);
   assign clr      = sw.resetBtn || wrap;
   assign load_vec = sw.preloadTime;
   assign inc      = {carry[5:0], tick};
   assign live     = stamp_t'(live_vec);
   // Minutes tens never carries out; the wrap clears the chain first.
   assign unused_carry = carry[6];

   for (genvar i = 0; i < 7; i++) begin : g_digit
      bcd_digit_counter #(
         .Modulus (digit_modulus(i))
      ) u_digit (
         .clk        (clk),
         .rst_n      (rst_n),
         .clr_i      (clr),
         .load_i     (load),
         .load_val_i (load_vec[i]),
         .inc_i      (inc[i]),
         .digit_o    (live_vec[i]),
         .carry_o    (carry[i])
      );
   end

   // ---------------- lap capture ----------------
`ifdef STOPWATCH_LAP_EN
   logic   lap_q, lap_d;
   stamp_t shadow_q, shadow_d;

   always_comb begin
      lap_d    = lap_q;
      shadow_d = shadow_q;
      if (sw.resetBtn) begin
         lap_d = 1'b0;
      end else if (lap_q && (sw.lapBtn || sw.stopBtn)) begin
         lap_d = 1'b0;
      end else if (!lap_q && sw.lapBtn && (state_q == StRunning)) begin
         lap_d    = 1'b1;
         shadow_d = live;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lap_q    <= 1'b0;
         shadow_q <= '0;
      end else begin
         lap_q    <= lap_d;
         shadow_q <= shadow_d;
      end
   end

   assign shown = lap_q ? shadow_q : live;
`else
   assign shown = live;
`endif

   // ---------------- outputs ----------------
   assign sw.enableTimer = enable_q;
   assign sw.running     = (state_q == StRunning);
   assign sw.overflow    = overflow_q;
   assign sw.msDigits    = {shown.ms2, shown.ms1, shown.ms0};
   assign sw.secDigits   = {shown.sec1, shown.sec0};
   assign sw.minDigits   = {shown.min1, shown.min0};

endmodule

// File: tb/tb_stopwatch_controller.sv
// Scoreboard bench for stopwatch_controller: stimulus pushes expected outputs
// into a queue, a monitor pops and compares them on the falling clock edge
// (or immediately on probe_ev for the asynchronous reset check).
module tb_stopwatch_controller;
   import stopwatch_pkg::*;

   localparam int unsigned MaxMin = 59;

   typedef struct {
      string       name;
      logic [7:0]  mn;
      logic [7:0]  sec;
      logic [11:0] ms;
      logic        run;
      logic        en;
      logic        ovf;
      int unsigned due;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   int unsigned cyc = 0;
   int          checks = 0;
   int          errors = 0;
   exp_t        sb_q[$];
   exp_t        e;
   event        probe_ev;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   stopwatch_controller_if sw ();

   stopwatch_controller #(
      .MAX_MINUTES (MaxMin)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .sw    (sw)
   );

   task automatic expect_out(input string name, input logic [7:0] mn, input logic [7:0] sec,
                             input logic [11:0] ms, input logic run, input logic en,
                             input logic ovf);
      exp_t x;
      x.name = name; x.mn = mn; x.sec = sec; x.ms = ms;
      x.run = run; x.en = en; x.ovf = ovf; x.due = cyc;
      sb_q.push_back(x);
   endtask

   task automatic drive(input logic st, input logic sp, input logic rs, input logic lp,
                        input logic tk);
      sw.startBtn = st; sw.stopBtn = sp; sw.resetBtn = rs; sw.lapBtn = lp;
      sw.oneMilliSecond = tk;
      @(posedge clk);
      #1;
      sw.startBtn = 1'b0; sw.stopBtn = 1'b0; sw.resetBtn = 1'b0; sw.lapBtn = 1'b0;
      sw.oneMilliSecond = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic preload_to(input stamp_t v);
      sw.preload = 1'b1;
      sw.preloadTime = v;
      @(posedge clk);
      #1;
      sw.preload = 1'b0;
   endtask

   // Monitor: compare every expectation that has come due.
   initial begin
      forever begin
         @(negedge clk or probe_ev);
         while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            e = sb_q.pop_front();
            checks++;
            if (sw.minDigits !== e.mn || sw.secDigits !== e.sec || sw.msDigits !== e.ms ||
                sw.running !== e.run || sw.enableTimer !== e.en || sw.overflow !== e.ovf) begin
               errors++;
               $display("FAIL %s: got %h:%h.%h run=%b en=%b ovf=%b, want %h:%h.%h run=%b en=%b ovf=%b",
                        e.name, sw.minDigits, sw.secDigits, sw.msDigits, sw.running,
                        sw.enableTimer, sw.overflow, e.mn, e.sec, e.ms, e.run, e.en, e.ovf);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      sw.startBtn = 1'b0; sw.stopBtn = 1'b0; sw.resetBtn = 1'b0; sw.lapBtn = 1'b0;
      sw.oneMilliSecond = 1'b0; sw.preload = 1'b0; sw.preloadTime = '0;

      // Reset state while rst_n is held low.
      #2;
      expect_out("reset_state", 8'h00, 8'h00, 12'h000, 1'b0, 1'b0, 1'b0);
      ->probe_ev;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // IDLE: ticks ignored; start+stop together is no request.
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      expect_out("idle_tick", 8'h00, 8'h00, 12'h000, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      expect_out("idle_start_stop", 8'h00, 8'h00, 12'h000, 1'b0, 1'b0, 1'b0);

      // Start, then 1234 ticks.
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_out("start", 8'h00, 8'h00, 12'h000, 1'b1, 1'b1, 1'b0);
      ticks(1234);
      expect_out("count_1234", 8'h00, 8'h01, 12'h234, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      expect_out("reset_btn", 8'h00, 8'h00, 12'h000, 1'b0, 1'b0, 1'b0);

      // Stop with a coincident tick at 009.
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      ticks(9);
      expect_out("at_009", 8'h00, 8'h00, 12'h009, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      expect_out("stop_tick", 8'h00, 8'h00, 12'h010, 1'b0, 1'b0, 1'b0);
      ticks(5);
      expect_out("paused_ticks", 8'h00, 8'h00, 12'h010, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_out("resume", 8'h00, 8'h00, 12'h010, 1'b1, 1'b1, 1'b0);
      ticks(3);
      expect_out("resume_013", 8'h00, 8'h00, 12'h013, 1'b1, 1'b1, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      expect_out("stop_over_start", 8'h00, 8'h00, 12'h013, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      // Wrap at MAX:59.999.
      preload_to(stamp_t'(28'h5959999));
      expect_out("preload_max", 8'h59, 8'h59, 12'h999, 1'b1, 1'b1, 1'b0);
      ticks(1);
      expect_out("wrap", 8'h00, 8'h00, 12'h000, 1'b1, 1'b1, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_out("wrap_pulse_end", 8'h00, 8'h00, 12'h000, 1'b1, 1'b1, 1'b0);
      ticks(1);
      expect_out("after_wrap", 8'h00, 8'h00, 12'h001, 1'b1, 1'b1, 1'b0);

      // Seconds carry into minutes.
      preload_to(stamp_t'(28'h0059999));
      ticks(1);
      expect_out("sec_carry", 8'h01, 8'h00, 12'h000, 1'b1, 1'b1, 1'b0);

      // Reset with a coincident tick at 00:05.500.
      preload_to(stamp_t'(28'h0005500));
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      expect_out("reset_tick", 8'h00, 8'h00, 12'h000, 1'b0, 1'b0, 1'b0);

      // Asynchronous reset mid-cycle while running.
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      ticks(10);
      expect_out("pre_rst", 8'h00, 8'h00, 12'h010, 1'b1, 1'b1, 1'b0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      expect_out("async_rst", 8'h00, 8'h00, 12'h000, 1'b0, 1'b0, 1'b0);
      ->probe_ev;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      ticks(5);
      expect_out("post_rst_ticks", 8'h00, 8'h00, 12'h000, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      ticks(2);
      expect_out("post_rst_start", 8'h00, 8'h00, 12'h002, 1'b1, 1'b1, 1'b0);

      // Lap behaviour at 00:02.000.
      preload_to(stamp_t'(28'h0002000));
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
`ifdef STOPWATCH_LAP_EN
      expect_out("lap_capture", 8'h00, 8'h02, 12'h000, 1'b1, 1'b1, 1'b0);
      ticks(300);
      expect_out("lap_hold", 8'h00, 8'h02, 12'h000, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      expect_out("lap_release", 8'h00, 8'h02, 12'h300, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      ticks(5);
      expect_out("lap_hold2", 8'h00, 8'h02, 12'h300, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      expect_out("lap_stop_release", 8'h00, 8'h02, 12'h305, 1'b0, 1'b0, 1'b0);
`else
      expect_out("lap_ignored", 8'h00, 8'h02, 12'h000, 1'b1, 1'b1, 1'b0);
      ticks(300);
      expect_out("lap_off_live", 8'h00, 8'h02, 12'h300, 1'b1, 1'b1, 1'b0);
`endif

      repeat (2) @(negedge clk);
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending, want 0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/stopwatch_controller.md
STOPWATCH_CONTROLLER -- requirements
Module: stopwatch_controller

Interface
REQ-001 SHALL have parameter MAX_MINUTES, default 59, the highest minutes value before wrap (legal range 1..99).
REQ-002 SHALL have port clk  input  1  system clock, 50 MHz; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port startBtn  input  1  one-cycle synchronous start request.
REQ-005 SHALL have port stopBtn  input  1  one-cycle synchronous stop request.
REQ-006 SHALL have port resetBtn  input  1  one-cycle synchronous clear request.
REQ-007 SHALL have port lapBtn  input  1  one-cycle synchronous lap request; ignored unless REQ-027 applies.
REQ-008 SHALL have port oneMilliSecond  input  1  one-cycle tick from the 1 ms timer.
REQ-009 SHALL have port enableTimer  output  1  registered enable to the 1 ms timer.
REQ-010 SHALL have port msDigits  output  12  three BCD digits of milliseconds, 000-999.
REQ-011 SHALL have port secDigits  output  8  two BCD digits of seconds, 00-59.
REQ-012 SHALL have port minDigits  output  8  two BCD digits of minutes, 00-MAX_MINUTES.
REQ-013 SHALL have port running  output  1  high while the state is RUNNING.
REQ-014 SHALL have port overflow  output  1  one-cycle pulse on wrap.

Function
REQ-015 SHALL implement the states IDLE, RUNNING and PAUSED in a registered FSM.
REQ-016 SHALL apply these transitions: IDLE/PAUSED + startBtn -> RUNNING; RUNNING + stopBtn -> PAUSED; any state + resetBtn -> IDLE with all digits cleared on the same edge.
REQ-017 SHALL apply this priority: resetBtn over stopBtn over startBtn; startBtn and stopBtn together in IDLE or PAUSED -> no state change.
REQ-018 SHALL drive enableTimer = 1 exactly when the state register is RUNNING (rises one clock after startBtn, falls one clock after stopBtn/resetBtn).
REQ-019 SHALL advance the time by 1 ms on each cycle where oneMilliSecond=1 and state=RUNNING; ticks are ignored in any other state.
REQ-020 SHALL count a tick that coincides with stopBtn; SHALL drop a tick that coincides with resetBtn.
REQ-021 SHALL cascade the digits: ms units 9->0 carries to ms tens, ms 999->000 carries to seconds units, seconds 59->00 carries to minutes.
REQ-022 SHALL treat a tick at MAX_MINUTES:59.999 as a wrap: all digits go to 0, overflow pulses for one cycle, and the state stays RUNNING.
REQ-023 SHALL register all digit outputs; each update is visible on the clock edge after the tick, i.e. one cycle of latency.
REQ-024 SHALL keep every BCD digit in 0-9 at all times and never emit a code from A to F.

Reset
REQ-025 SHALL, while rst_n=0, immediately force: state IDLE, enableTimer=0, all digits 0, running=0, overflow=0, and lap freeze cleared.
REQ-026 SHALL, after rst_n is deasserted mid-count, resume operation only after a fresh startBtn.

Configuration
REQ-027 SHALL compile lap capture in when STOPWATCH_LAP_EN is defined: lapBtn in RUNNING captures the current digits into a shadow register and freezes the outputs on it while the internal count continues. A second lapBtn, or stopBtn, releases the freeze, and the live value appears on the next edge. resetBtn clears the freeze.
REQ-028 SHALL, without STOPWATCH_LAP_EN, omit the shadow register, leave lapBtn unconnected internally, and always show the live count.

Structure
REQ-029 SHALL place the state enum, a 4-bit BCD digit typedef and the constants MS_MAX=999 and SEC_MAX=59 in the shared package stopwatch_pkg.
REQ-030 SHALL instantiate the sub-module bcd_digit_counter (modulo-N BCD digit with clear, carry-in and carry-out) once per digit.

Verification
REQ-031 SHALL cover: startBtn, then 1234 ticks -> digits 00:01.234, running=1, enableTimer=1 from the cycle after start.
REQ-032 SHALL cover: stopBtn with a tick in the same cycle at 00:00.009 -> 00:00.010 and PAUSED; 5 further ticks -> unchanged; startBtn -> resumes counting from 010.
REQ-033 SHALL cover: preload to MAX_MINUTES:59.999, then a tick -> 00:00.000, overflow high for exactly 1 cycle, still RUNNING.
REQ-034 SHALL cover: resetBtn with a tick in the same cycle at 00:05.500 -> IDLE, 00:00.000, enableTimer=0 on the next edge.
REQ-035 SHALL cover: rst_n pulsed low mid-cycle while RUNNING -> outputs zero immediately without waiting for a clock; ticks after release are ignored until startBtn.
REQ-036 SHALL cover, with STOPWATCH_LAP_EN: lapBtn at 00:02.000, then 300 ticks -> outputs hold 00:02.000; second lapBtn -> 00:02.300.
